uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between up to NUM_FONTES event senders, such as the full-map sender and the other payload senders. It grants the transmitter to one requester at a time using round-robin priority. While a sender holds the grant, the block enables it, forwards its byte strobes and data to the UART, and feeds it the UART busy flag. A watchdog reclaims the transmitter if the granted sender stalls.

---
 rtl/uart_tx_arbiter.sv | 93 +++++++++
 tb/tb_uart_tx_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among several senders, with a no-progress watchdog
module uart_tx_arbiter #(
  parameter int NUM_FONTES     = 4,
  parameter int TIMEOUT_CICLOS = 1_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_FONTES-1:0]   pedido,
  input  logic [NUM_FONTES-1:0]   iniciar_envio_fonte,
  input  logic [8*NUM_FONTES-1:0] dado_fonte,
  input  logic [NUM_FONTES-1:0]   concluido_fonte,
  input  logic                    uart_ocupado,
  output logic [NUM_FONTES-1:0]   habilitar_fonte,
  output logic [NUM_FONTES-1:0]   uart_ocupado_fonte,
  output logic                    iniciar_envio,
  output logic [7:0]              dado_saida,
  output logic [NUM_FONTES-1:0]   concedido,
  output logic                    erro_timeout
);
  localparam int IW = $clog2(NUM_FONTES);
  localparam int WW = $clog2(TIMEOUT_CICLOS + 1);
  typedef enum logic [1:0] {OCIOSO, ENVIANDO, LIBERA} estado_t;
  estado_t estado_q, estado_d;
  logic [IW-1:0] idx_q, idx_d, ultimo_q, ultimo_d, sel;
  logic [WW-1:0] wd_q, wd_d;
  logic erro_q, erro_d, achou, envia, strobe;
  int cand;
  always_comb begin
    sel = '0;
    achou = 1'b0;
    cand = 0;
    for (int j = 0; j < NUM_FONTES; j++) begin
      cand = int'(ultimo_q) + 1 + j;
      cand = cand >= NUM_FONTES ? cand - NUM_FONTES : cand;
      if (!achou && pedido[IW'(cand)]) begin
        achou = 1'b1;
        sel = IW'(cand);
      end
    end
  end
  assign envia  = estado_q == ENVIANDO;
  assign strobe = iniciar_envio_fonte[idx_q];
  always_comb begin
    estado_d = estado_q;
    idx_d = idx_q;
    ultimo_d = ultimo_q;
    wd_d = wd_q;
    erro_d = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (achou) begin
          idx_d = sel;
          wd_d = WW'(TIMEOUT_CICLOS);
          estado_d = ENVIANDO;
        end
      end
      ENVIANDO: begin
        wd_d = strobe ? WW'(TIMEOUT_CICLOS) : (wd_q == '0 ? '0 : wd_q - WW'(1));
        if (concluido_fonte[idx_q]) estado_d = LIBERA;
        else if (!strobe && wd_q <= WW'(1)) begin
          erro_d = 1'b1;
          estado_d = LIBERA;
        end
      end
      LIBERA: begin
        ultimo_d = idx_q;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      idx_q <= '0;
      ultimo_q <= IW'(NUM_FONTES - 1);
      wd_q <= '0;
      erro_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      idx_q <= idx_d;
      ultimo_q <= ultimo_d;
      wd_q <= wd_d;
      erro_q <= erro_d;
    end
  end
  assign concedido          = envia ? ({{(NUM_FONTES-1){1'b0}}, 1'b1} << idx_q) : '0;
  assign habilitar_fonte    = concedido;
  assign uart_ocupado_fonte = ~concedido | {NUM_FONTES{uart_ocupado}};
  assign iniciar_envio      = envia & strobe;
  assign dado_saida         = envia ? dado_fonte[{idx_q, 3'b000} +: 8] : 8'h00;
  assign erro_timeout       = erro_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter (4 senders, 16-cycle watchdog)
module tb_uart_tx_arbiter;
  logic clock, reset, uart_ocupado, iniciar_envio, erro_timeout;
  logic [3:0] pedido, iniciar_envio_fonte, concluido_fonte, habilitar_fonte, uart_ocupado_fonte, concedido;
  logic [31:0] dado_fonte;
  logic [7:0] dado_saida;
  int n_vec = 0;
  int n_err = 0;
  logic [3:0] ordem [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  uart_tx_arbiter #(.NUM_FONTES(4), .TIMEOUT_CICLOS(16)) dut (
    .clock(clock), .reset(reset), .pedido(pedido),
    .iniciar_envio_fonte(iniciar_envio_fonte), .dado_fonte(dado_fonte),
    .concluido_fonte(concluido_fonte), .uart_ocupado(uart_ocupado),
    .habilitar_fonte(habilitar_fonte), .uart_ocupado_fonte(uart_ocupado_fonte),
    .iniciar_envio(iniciar_envio), .dado_saida(dado_saida),
    .concedido(concedido), .erro_timeout(erro_timeout)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    pedido = '0;
    iniciar_envio_fonte = '0;
    concluido_fonte = '0;
    dado_fonte = '0;
    uart_ocupado = 1'b0;
    #1 reset = 1'b0;
    tick();
    tick();
    chk("rst_concedido", 32'(concedido), 32'h0);
    chk("rst_habilitar", 32'(habilitar_fonte), 32'h0);
    chk("rst_iniciar", 32'(iniciar_envio), 32'h0);
    chk("rst_dado", 32'(dado_saida), 32'h0);
    chk("rst_erro", 32'(erro_timeout), 32'h0);
    chk("rst_ocupado_fonte", 32'(uart_ocupado_fonte), 32'hF);
    reset = 1'b1;
    tick();
    tick();
    tick();
    chk("idle_concedido", 32'(concedido), 32'h0);
    pedido = 4'b0100;
    dado_fonte[31:24] = 8'h55;
    tick();
    chk("s2_concedido", 32'(concedido), 32'h4);
    chk("s2_habilitar", 32'(habilitar_fonte), 32'h4);
    chk("s2_ocupado_fonte", 32'(uart_ocupado_fonte), 32'hB);
    iniciar_envio_fonte = 4'b0100;
    dado_fonte[23:16] = 8'hAC;
    #1;
    chk("s2_b0_iniciar", 32'(iniciar_envio), 32'h1);
    chk("s2_b0_dado", 32'(dado_saida), 32'hAC);
    tick();
    iniciar_envio_fonte = '0;
    #1;
    chk("s2_gap_iniciar", 32'(iniciar_envio), 32'h0);
    iniciar_envio_fonte = 4'b0100;
    dado_fonte[23:16] = 8'h01;
    #1;
    chk("s2_b1_dado", 32'(dado_saida), 32'h01);
    tick();
    dado_fonte[23:16] = 8'h02;
    #1;
    chk("s2_b2_iniciar", 32'(iniciar_envio), 32'h1);
    chk("s2_b2_dado", 32'(dado_saida), 32'h02);
    tick();
    iniciar_envio_fonte = '0;
    concluido_fonte = 4'b0100;
    pedido = '0;
    #1;
    chk("s2_held_at_concl", 32'(concedido), 32'h4);
    tick();
    concluido_fonte = '0;
    chk("s2_released", 32'(concedido), 32'h0);
    chk("s2_no_erro", 32'(erro_timeout), 32'h0);
    chk("s2_libera_dado", 32'(dado_saida), 32'h0);
    tick();
    reset = 1'b0;
    #1 reset = 1'b1;
    pedido = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr%0d_grant", i), 32'(concedido), 32'(ordem[i]));
      iniciar_envio_fonte = ordem[i];
      concluido_fonte = ordem[i];
      #1;
      chk($sformatf("rr%0d_last_strobe", i), 32'(iniciar_envio), 32'h1);
      tick();
      iniciar_envio_fonte = '0;
      concluido_fonte = '0;
      chk($sformatf("rr%0d_gap1", i), 32'(concedido), 32'h0);
      tick();
      chk($sformatf("rr%0d_gap2", i), 32'(concedido), 32'h0);
    end
    pedido = 4'b0010;
    tick();
    chk("iso_grant", 32'(concedido), 32'h2);
    dado_fonte[15:8] = 8'h11;
    iniciar_envio_fonte = 4'b1000;
    #1;
    chk("iso_iniciar", 32'(iniciar_envio), 32'h0);
    chk("iso_dado", 32'(dado_saida), 32'h11);
    chk("iso_ocupado_fonte", 32'(uart_ocupado_fonte), 32'hD);
    uart_ocupado = 1'b1;
    #1;
    chk("iso_ocupado_busy", 32'(uart_ocupado_fonte), 32'hF);
    uart_ocupado = 1'b0;
    iniciar_envio_fonte = '0;
    concluido_fonte = 4'b0010;
    pedido = '0;
    tick();
    concluido_fonte = '0;
    tick();
    pedido = 4'b0011;
    tick();
    chk("wd_grant", 32'(concedido), 32'h1);
    pedido = 4'b0010;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("wd_hold%0d", i), 32'({erro_timeout, concedido}), 32'h01);
    end
    tick();
    chk("wd_erro", 32'(erro_timeout), 32'h1);
    chk("wd_revoked", 32'(concedido), 32'h0);
    tick();
    chk("wd_erro_once", 32'(erro_timeout), 32'h0);
    tick();
    chk("wd_next_grant", 32'(concedido), 32'h2);
    concluido_fonte = 4'b0010;
    pedido = '0;
    tick();
    concluido_fonte = '0;
    tick();
    pedido = 4'b0100;
    tick();
    chk("rm_grant", 32'(concedido), 32'h4);
    iniciar_envio_fonte = 4'b0100;
    dado_fonte[23:16] = 8'hAA;
    tick();
    dado_fonte[23:16] = 8'hBB;
    #1;
    chk("rm_b1_iniciar", 32'(iniciar_envio), 32'h1);
    reset = 1'b0;
    #1;
    chk("rm_concedido", 32'(concedido), 32'h0);
    chk("rm_iniciar", 32'(iniciar_envio), 32'h0);
    chk("rm_ocupado_fonte", 32'(uart_ocupado_fonte), 32'hF);
    tick();
    iniciar_envio_fonte = '0;
    pedido = 4'b0101;
    reset = 1'b1;
    tick();
    chk("rm_first_after", 32'(concedido), 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
